frame_uart_tx: RTL and testbench
================================

# frame_uart_tx

Serializes one 80-bit code frame onto the UART line as ten back-to-back 8N1 bytes. It is the transmit end of the frame link whose receive end produces `odata`/`datavalid`. It sits between the processor's `code_out`/`flag` outputs and the board `TX` pin. A peer receiver therefore reassembles exactly the 80 bits that were presented here.

## Interface
- `CLKS_PER_BIT`, 868, `msclk` cycles per UART bit (100 MHz / 115200); legal range 2..65535
- `FRAME_BYTES`, 10, bytes per frame; frame width is 8*FRAME_BYTES bits

- `msclk`  in  1  system clock; all state changes on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `idata`  in  8*FRAME_BYTES  frame to send; sampled only on an accepted `senddata`
- `senddata`  in  1  send request, level-sampled each cycle
- `busy`  out  1  high while a frame is latched or being shifted
- `done`  out  1  one-cycle pulse when the last stop bit of a frame completes
- `TX`  out  1  UART line; idle high

## Operation
- Reset values while `rst_n`=0, applied immediately: `TX`=1, `busy`=0, `done`=0, state IDLE, all counters 0, frame register 0.
- State machine: IDLE, START, DATA, STOP.
- **IDLE:**
  - `TX`=1.
  - If `senddata`=1, copy `idata` into the frame register, clear the byte index, and go to START.
- **START:**
  - `TX`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:**
  - `TX` = current byte bit [bit index]; data bits go out LSB first.
  - Each bit lasts CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- **STOP:**
  - `TX`=1 for CLKS_PER_BIT cycles.
  - If byte index < FRAME_BYTES-1: increment the byte index and go to START, with no idle gap.
  - Otherwise: go to IDLE and pulse `done`.
- Byte order: byte 0 is `idata[8*FRAME_BYTES-1 -: 8]` (the most significant byte, bits [79:72]). The last byte is `idata[7:0]`.
- `senddata` while `busy`=1 is ignored; nothing is queued.
- Changes to `idata` after acceptance have no effect on the frame in flight.
- Baud counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - It counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - It never free-runs in IDLE; it is held at 0 there.
- Bit index is 3 bits and wraps 7→0 at the end of DATA. Byte index counts 0..FRAME_BYTES-1.
- Reset asserted mid-frame aborts the frame immediately:
  - `TX` returns to 1 with no partial stop bit.
  - `done` is not pulsed.

## Timing
- `senddata`=1 sampled at rising edge N while IDLE: `busy`=1 and `TX`=0 (start bit) from edge N.
- Each bit occupies exactly CLKS_PER_BIT cycles; one byte is 10*CLKS_PER_BIT cycles.
- A frame occupies FRAME_BYTES*10*CLKS_PER_BIT cycles, i.e. 100*CLKS_PER_BIT with defaults.
- At edge N + FRAME_BYTES*10*CLKS_PER_BIT:
  - `busy`=0.
  - `done`=1 for exactly one cycle.
  - `TX` remains 1.
- Back-to-back frames: `senddata`=1 in the cycle where `done`=1 (`busy`=0) is accepted. The next start bit then begins at the following edge, giving a minimum one-cycle idle high between frames.
- `busy` and `done` are never high in the same cycle.
- `TX`, `busy` and `done` are registered outputs: no combinational path from inputs to outputs.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FRAME_BYTES=10.
- **Reset:**
  - Stimulus: hold `rst_n`=0 for 5 cycles, then release.
  - Required: `TX`=1, `busy`=0, `done`=0 throughout and for 20 idle cycles after release.
- **Single frame:**
  - Stimulus: `idata`=80'h0102_0304_0506_0708_090A, one-cycle `senddata`.
  - Required: a line decoder sampling mid-bit recovers bytes 01,02,…,0A in order.
  - Required: each byte has start bit 0 and stop bit 1.
  - Required: `busy` high for exactly 400 cycles, then one-cycle `done`.
- **Bit order:**
  - Stimulus: `idata`=80'h80_00…00_01.
  - Required: the first byte's data bits on `TX` are 0,0,0,0,0,0,0,1.
  - Required: the last byte's data bits are 1,0,0,0,0,0,0,0.
- **Ignored request / input stability:**
  - Stimulus: assert `senddata` again at cycle 150 of a frame, and change `idata` to all ones at the same time.
  - Required: the transmitted frame is unchanged.
  - Required: no second frame starts after `done`.
- **Back-to-back:**
  - Stimulus: hold `senddata`=1 continuously, with `idata` 80'hAA…AA then 80'h55…55.
  - Required: the second frame's start bit begins exactly one cycle after the `done` pulse.
  - Required: each frame lasts 400 cycles.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n`=0 during a DATA bit of byte 3 where `TX`=0.
  - Required: `TX`=1 and `busy`=0 without waiting for a clock edge; no `done` pulse.
  - Required: a following `senddata` transmits a complete, correct frame.

Source files
------------

// File: rtl/frame_uart_tx.sv
// frame_uart_tx: sends one multi-byte frame as back-to-back 8N1 UART bytes.
// The most significant byte of the frame goes first, and each byte is sent
// LSB first. TX, busy and done all come straight from flops.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for senddata; baud counter held at 0
// START | start bit (TX=0) of the current byte
// DATA  | data bits of the current byte, LSB first
// STOP  | stop bit (TX=1); then the next byte's START or back to IDLE
module frame_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BYTES  = 10
) (
  input  logic                     msclk,
  input  logic                     rst_n,
  input  logic [8*FRAME_BYTES-1:0] idata,
  input  logic                     senddata,
  output logic                     busy,
  output logic                     done,
  output logic                     TX
);

  localparam int FW     = 8 * FRAME_BYTES;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [BAUD_W-1:0]   baud_d;
  logic [2:0]          bit_q;
  logic [2:0]          bit_d;
  logic [BYTE_W-1:0]   byte_q;
  logic [FW-1:0]       frame_q;
  logic                tx_q;
  logic                busy_q;
  logic                done_q;

  logic                bit_end;
  logic [7:0]          cur_byte;

  // The byte on the line always sits in the top eight bits of the frame
  // register; the register is shifted up by a byte at every stop bit.
  assign cur_byte = frame_q[FW-1 -: 8];
  assign bit_end  = (baud_q == BAUD_LAST);
  assign baud_d   = bit_end ? '0 : baud_q + BAUD_W'(1);
  assign bit_d    = bit_q + 3'd1;

  // Sequencer: bit timing, byte stepping and registered line/status outputs.
  always_ff @(posedge msclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (senddata) begin
            frame_q <= idata;
            byte_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          baud_q <= baud_d;
          if (bit_end) begin
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          baud_q <= baud_d;
          if (bit_end) begin
            bit_q <= bit_d;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q <= cur_byte[bit_d];
            end
          end
        end
        STOP: begin
          baud_q <= baud_d;
          if (bit_end) begin
            if (byte_q != BYTE_LAST) begin
              // Next byte starts immediately, with no idle gap.
              byte_q  <= byte_q + BYTE_W'(1);
              frame_q <= frame_q << 8;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          baud_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign TX   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_frame_uart_tx.sv
// Directed bench for frame_uart_tx with CLKS_PER_BIT=4, FRAME_BYTES=10.
// Outputs are sampled on the falling edge of msclk.
module tb_frame_uart_tx;

  localparam int CPB = 4;
  localparam int FB  = 10;

  localparam logic [79:0] D_SINGLE = 80'h0102_0304_0506_0708_090A;
  localparam logic [79:0] D_ORDER  = 80'h8000_0000_0000_0000_0001;
  localparam logic [79:0] D_AA     = {10{8'hAA}};
  localparam logic [79:0] D_55     = {10{8'h55}};

  logic        msclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [79:0] idata = '0;
  logic        senddata = 1'b0;
  logic        busy;
  logic        done;
  logic        TX;

  int errors = 0;
  int checks = 0;

  logic [79:0] dec;
  int          ferr;
  logic [7:0]  first_seq;
  logic [7:0]  last_seq;

  frame_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(FB)) dut (
    .msclk   (msclk),
    .rst_n   (rst_n),
    .idata   (idata),
    .senddata(senddata),
    .busy    (busy),
    .done    (done),
    .TX      (TX)
  );

  always #5 msclk = ~msclk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge right after the accepting rising edge.
  // Samples every bit slot mid-bit; leaves at the falling edge after
  // accept+398 cycles.
  task automatic decode(output logic [79:0] data, output int bad,
                        output logic [7:0] fseq, output logic [7:0] lseq);
    logic [7:0] b;
    data = '0; bad = 0; fseq = '0; lseq = '0; b = '0;
    for (int by = 0; by < FB; by++) begin
      for (int s = 0; s < 10; s++) begin
        if (by == 0 && s == 0) repeat (2) @(negedge msclk);
        else                   repeat (CPB) @(negedge msclk);
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        if (s == 0 && TX !== 1'b0) bad++;
        if (s == 9 && TX !== 1'b1) bad++;
        if (s >= 1 && s <= 8) begin
          b[s-1] = TX;
          if (by == 0)      fseq[8-s] = TX;
          if (by == FB - 1) lseq[8-s] = TX;
        end
      end
      data[79 - 8*by -: 8] = b;
    end
  endtask

  // Checks the frame end; leaves at the falling edge of the done cycle.
  task automatic end_check(input string tag);
    @(negedge msclk);
    chk({tag, " last busy cycle"}, {77'd0, TX, busy, done}, 80'b110);
    @(negedge msclk);
    chk({tag, " done pulse"}, {77'd0, TX, busy, done}, 80'b101);
  endtask

  // Drives a one-cycle request; leaves at the falling edge after acceptance.
  task automatic send(input logic [79:0] d);
    idata = d;
    senddata = 1'b1;
    @(negedge msclk);
    senddata = 1'b0;
  endtask

  initial begin
    // Reset held for 5 cycles, then 20 idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge msclk);
      chk("reset hold", {77'd0, TX, busy, done}, 80'b100);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge msclk);
      chk("post-reset idle", {77'd0, TX, busy, done}, 80'b100);
    end

    // Single frame.
    send(D_SINGLE);
    chk("single start edge", {78'd0, TX, busy}, 80'b01);
    decode(dec, ferr, first_seq, last_seq);
    chk("single data", dec, D_SINGLE);
    chk("single framing", 80'(ferr), 80'd0);
    end_check("single");
    @(negedge msclk);
    chk("single after done", {77'd0, TX, busy, done}, 80'b100);

    // Bit order.
    repeat (3) @(negedge msclk);
    send(D_ORDER);
    decode(dec, ferr, first_seq, last_seq);
    chk("order first byte bits", {72'd0, first_seq}, 80'h01);
    chk("order last byte bits", {72'd0, last_seq}, 80'h80);
    chk("order data", dec, D_ORDER);
    chk("order framing", 80'(ferr), 80'd0);
    end_check("order");

    // Request and idata change mid-frame are ignored.
    repeat (3) @(negedge msclk);
    send(D_SINGLE);
    fork
      decode(dec, ferr, first_seq, last_seq);
      begin
        repeat (149) @(negedge msclk);
        senddata = 1'b1;
        idata = '1;
        @(negedge msclk);
        senddata = 1'b0;
      end
    join
    chk("ignored data", dec, D_SINGLE);
    chk("ignored framing", 80'(ferr), 80'd0);
    end_check("ignored");
    for (int i = 0; i < 20; i++) begin
      @(negedge msclk);
      chk("no second frame", {77'd0, TX, busy, done}, 80'b100);
    end

    // Back-to-back with senddata held high.
    idata = D_AA;
    senddata = 1'b1;
    @(negedge msclk);
    chk("b2b first start", {78'd0, TX, busy}, 80'b01);
    decode(dec, ferr, first_seq, last_seq);
    chk("b2b frame1 data", dec, D_AA);
    chk("b2b frame1 framing", 80'(ferr), 80'd0);
    end_check("b2b frame1");
    idata = D_55;
    @(negedge msclk);
    chk("b2b second start", {77'd0, TX, busy, done}, 80'b010);
    decode(dec, ferr, first_seq, last_seq);
    chk("b2b frame2 data", dec, D_55);
    chk("b2b frame2 framing", 80'(ferr), 80'd0);
    end_check("b2b frame2");
    senddata = 1'b0;
    @(negedge msclk);
    chk("b2b idle", {77'd0, TX, busy, done}, 80'b100);

    // Reset during bit 0 of byte 3 (0x04, so TX=0).
    repeat (3) @(negedge msclk);
    send(D_SINGLE);
    repeat (125) @(negedge msclk);
    chk("mid-frame TX low", {78'd0, TX, busy}, 80'b01);
    rst_n = 1'b0;
    #1;
    chk("async reset", {77'd0, TX, busy, done}, 80'b100);
    for (int i = 0; i < 3; i++) begin
      @(negedge msclk);
      chk("reset no done", {77'd0, TX, busy, done}, 80'b100);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge msclk);
    chk("after reset idle", {77'd0, TX, busy, done}, 80'b100);
    send(D_SINGLE);
    decode(dec, ferr, first_seq, last_seq);
    chk("after reset data", dec, D_SINGLE);
    chk("after reset framing", 80'(ferr), 80'd0);
    end_check("after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
